// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong match sequencer (serve, point pause, scoring, game over).
// Define PONG_AUTO_SERVE_EN to serve automatically after AUTO_SERVE_FRAMES frames in SERVE_WAIT.
module pong_game_ctrl #(
    parameter int WIN_SCORE         = 7,
    parameter int PAUSE_FRAMES      = 60,
    parameter int AUTO_SERVE_FRAMES = 180
) (
    input  logic       CLK_50,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       serve_pulse,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       ball_run,
    output logic       ball_center,
    output logic       serve_dir,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       game_over,
    output logic       winner
);
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] SERVE_WAIT  = 3'd1;
    localparam logic [2:0] PLAY        = 3'd2;
    localparam logic [2:0] POINT_PAUSE = 3'd3;
    localparam logic [2:0] GAME_OVER   = 3'd4;
    localparam logic [3:0] WIN         = 4'(WIN_SCORE);
    localparam logic [7:0] PAUSE_LOAD  = 8'(PAUSE_FRAMES);
`ifdef PONG_AUTO_SERVE_EN
    localparam logic       AUTO_EN     = 1'b1;
`else
    localparam logic       AUTO_EN     = 1'b0;
`endif
    // Without auto-serve the counter simply rests at zero while waiting to serve.
    localparam logic [7:0] SERVE_LOAD  = AUTO_EN ? 8'(AUTO_SERVE_FRAMES) : 8'd0;

    logic [2:0] state;
    logic [7:0] cnt;
    logic       auto_fire;
    logic       pause_done;
    logic       match_won;

    always_comb begin
        auto_fire  = AUTO_EN && frame_tick && cnt <= 8'd1;
        pause_done = frame_tick && cnt <= 8'd1;
        match_won  = score_p1 == WIN || score_p2 == WIN;
    end

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            ball_run    <= 1'b0;
            ball_center <= 1'b0;
            serve_dir   <= 1'b1;
            score_p1    <= 4'd0;
            score_p2    <= 4'd0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
        end else begin
            ball_center <= 1'b0;
            case (state)
                IDLE: begin
                    state       <= SERVE_WAIT;
                    ball_center <= 1'b1;
                    cnt         <= SERVE_LOAD;
                end
                SERVE_WAIT: begin
                    if (serve_pulse || auto_fire) begin
                        state    <= PLAY;
                        ball_run <= 1'b1;
                        cnt      <= 8'd0;
                    end else if (AUTO_EN && frame_tick) begin
                        cnt <= cnt - 8'd1;
                    end
                end
                PLAY: begin
                    // A simultaneous right miss is dropped in favour of the left one.
                    if (miss_left || miss_right) begin
                        state     <= POINT_PAUSE;
                        ball_run  <= 1'b0;
                        cnt       <= PAUSE_LOAD;
                        serve_dir <= !miss_left;
                        if (miss_left)
                            score_p2 <= (score_p2 == WIN) ? score_p2 : score_p2 + 4'd1;
                        else
                            score_p1 <= (score_p1 == WIN) ? score_p1 : score_p1 + 4'd1;
                    end
                end
                POINT_PAUSE: begin
                    if (pause_done) begin
                        ball_center <= 1'b1;
                        state       <= match_won ? GAME_OVER : SERVE_WAIT;
                        cnt         <= match_won ? 8'd0 : SERVE_LOAD;
                        game_over   <= match_won;
                        winner      <= match_won ? (score_p2 == WIN) : winner;
                    end else if (frame_tick) begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GAME_OVER: begin
                    if (serve_pulse) begin
                        state       <= SERVE_WAIT;
                        ball_center <= 1'b1;
                        game_over   <= 1'b0;
                        serve_dir   <= 1'b1;
                        score_p1    <= 4'd0;
                        score_p2    <= 4'd0;
                        cnt         <= SERVE_LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed scoreboard bench for pong_game_ctrl.
module tb_pong_game_ctrl;
    logic       CLK_50 = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       serve_pulse = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       ball_run, ball_center, serve_dir, game_over, winner;
    logic [3:0] score_p1, score_p2;

    typedef struct {
        string       tag;
        logic [12:0] v;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    pong_game_ctrl #(.WIN_SCORE(7), .PAUSE_FRAMES(60), .AUTO_SERVE_FRAMES(3)) dut (
        .CLK_50(CLK_50), .reset(reset), .frame_tick(frame_tick),
        .serve_pulse(serve_pulse), .miss_left(miss_left), .miss_right(miss_right),
        .ball_run(ball_run), .ball_center(ball_center), .serve_dir(serve_dir),
        .score_p1(score_p1), .score_p2(score_p2), .game_over(game_over), .winner(winner)
    );

    always #5 CLK_50 = ~CLK_50;

    function automatic logic [12:0] pk(input logic run, ctr, dir, input logic [3:0] p1, p2,
                                       input logic go, win);
        return {run, ctr, dir, p1, p2, go, win};
    endfunction

    // One clock with the given one-cycle inputs; outputs checked 1 time unit after the edge.
    task automatic step(input logic r, sv, ft, ml, mr, input string tag, input logic [12:0] e);
        exp_t        x;
        logic [12:0] obs;
        q.push_back('{tag, e});
        reset = r;
        serve_pulse = sv;
        frame_tick = ft;
        miss_left = ml;
        miss_right = mr;
        @(posedge CLK_50);
        #1;
        reset = 0;
        serve_pulse = 0;
        frame_tick = 0;
        miss_left = 0;
        miss_right = 0;
        x = q.pop_front();
        // winner only carries meaning while game_over is high
        obs = pk(ball_run, ball_center, serve_dir, score_p1, score_p2, game_over, game_over & winner);
        total++;
        assert (obs === x.v) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", x.tag, obs, x.v);
        end
    endtask

    task automatic pause_out(input logic dir, input logic [3:0] p1, p2, input logic go, win);
        for (int i = 0; i < 60; i++)
            step(0, 0, 1, 0, 0, "pause", pk(0, i == 59, dir, p1, p2, (i == 59) & go, (i == 59) & win));
    endtask

    initial begin
        step(1, 0, 0, 0, 0, "reset", pk(0, 0, 1, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, "center_after_reset", pk(0, 1, 1, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, "serve_wait", pk(0, 0, 1, 0, 0, 0, 0));
        step(0, 0, 1, 0, 0, "tick_in_serve_wait", pk(0, 0, 1, 0, 0, 0, 0));
        step(0, 0, 0, 1, 0, "miss_in_serve_wait", pk(0, 0, 1, 0, 0, 0, 0));
        step(0, 1, 0, 0, 0, "serve", pk(1, 0, 1, 0, 0, 0, 0));
        step(0, 1, 0, 0, 0, "serve_in_play", pk(1, 0, 1, 0, 0, 0, 0));
        step(0, 0, 1, 0, 1, "miss_right", pk(0, 0, 1, 1, 0, 0, 0));
        step(0, 1, 0, 0, 0, "serve_in_pause", pk(0, 0, 1, 1, 0, 0, 0));
        pause_out(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, "back_to_serve_wait", pk(0, 0, 1, 1, 0, 0, 0));
        step(0, 1, 0, 0, 0, "serve2", pk(1, 0, 1, 1, 0, 0, 0));
        step(0, 0, 0, 1, 1, "both_miss", pk(0, 0, 0, 1, 1, 0, 0));
        pause_out(0, 1, 1, 0, 0);
        for (int k = 2; k <= 7; k++) begin
            step(0, 1, 0, 0, 0, "serve_p2_run", pk(1, 0, 0, 1, 4'(k - 1), 0, 0));
            step(0, 0, 0, 1, 0, "miss_left", pk(0, 0, 0, 1, 4'(k), 0, 0));
            pause_out(0, 1, 4'(k), k == 7, k == 7);
        end
        step(0, 0, 0, 1, 0, "miss_in_game_over", pk(0, 0, 0, 1, 7, 1, 1));
        step(0, 0, 1, 0, 1, "tick_in_game_over", pk(0, 0, 0, 1, 7, 1, 1));
        step(0, 1, 0, 0, 0, "restart", pk(0, 1, 1, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, "restart_wait", pk(0, 0, 1, 0, 0, 0, 0));
        step(0, 1, 0, 0, 0, "serve3", pk(1, 0, 1, 0, 0, 0, 0));
        step(1, 0, 0, 1, 0, "reset_mid_play", pk(0, 0, 1, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, "center_after_reset2", pk(0, 1, 1, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, "serve_wait2", pk(0, 0, 1, 0, 0, 0, 0));
`ifdef PONG_AUTO_SERVE_EN
        step(0, 0, 1, 0, 0, "auto_tick1", pk(0, 0, 1, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, "auto_idle", pk(0, 0, 1, 0, 0, 0, 0));
        step(0, 0, 1, 0, 0, "auto_tick2", pk(0, 0, 1, 0, 0, 0, 0));
        step(0, 0, 1, 0, 0, "auto_serve", pk(1, 0, 1, 0, 0, 0, 0));
`else
        for (int i = 0; i < 300; i++)
            step(0, 0, 1, 0, 0, "no_auto_serve", pk(0, 0, 1, 0, 0, 0, 0));
`endif
        step(0, 0, 0, 1, 0, "late_miss", pk(
`ifdef PONG_AUTO_SERVE_EN
            0, 0, 0, 0, 1, 0, 0
`else
            0, 0, 1, 0, 0, 0, 0
`endif
        ));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
